// File: rtl/ulpi_phy_responder.sv
// rtl/ulpi_phy_responder.sv - ULPI PHY emulator: register TXCMD write/read, RXCMD on line-state change, PHY reset
module ulpi_phy_responder #(
  parameter int STARTUP_CYCLES = 4,
  parameter int RESET_CYCLES   = 8
) (
  input  logic       USB_CLKIN,
  input  logic       NRST,
  input  logic [7:0] DATA_IN,
  output logic [7:0] DATA_OUT,
  output logic       DATA_OE,
  output logic       DIR,
  output logic       NXT,
  input  logic       STP,
  input  logic [1:0] LINE_STATE,
  input  logic [1:0] VBUS_STATE,
  output logic [7:0] FUNC_CTRL,
  output logic [7:0] OTG_CTRL
);

  typedef enum logic [3:0] {
    STARTUP, IDLE, W_ACK, W_DATA, W_STP, R_ACK, R_TURN1, R_DATA, R_TURN2,
    X_TURN1, X_RXCMD, X_TURN2, PHY_RST
  } state_t;

  localparam logic [15:0] STARTUP_LAST = 16'(STARTUP_CYCLES - 1);
  localparam logic [15:0] RESET_LAST   = 16'(RESET_CYCLES - 1);

  state_t      state, state_n;
  logic [15:0] cnt;
  logic [5:0]  addr;
  logic [7:0]  hold;
  logic [7:0]  func_ctrl, if_ctrl, otg_ctrl;
  logic [7:0]  rd_data;
  logic        pending;
  logic [3:0]  last_rpt;
  logic [3:0]  cur_rpt;
  logic        rst_hit;

  assign cur_rpt   = {VBUS_STATE, LINE_STATE};
  assign FUNC_CTRL = func_ctrl;
  assign OTG_CTRL  = otg_ctrl;
  // Only a load or set of FuncCtrl can raise the reset bit.
  assign rst_hit   = ((addr == 6'h04) || (addr == 6'h05)) && hold[5];

  always_comb begin
    state_n = state;
    case (state)
      STARTUP: if (cnt == STARTUP_LAST) state_n = IDLE;
      IDLE: begin
        if (DATA_IN[7:6] == 2'b10)      state_n = W_ACK;
        else if (DATA_IN[7:6] == 2'b11) state_n = R_ACK;
        else if (pending)               state_n = X_TURN1;
      end
      W_ACK:   state_n = W_DATA;
      W_DATA:  state_n = W_STP;
      W_STP:   if (STP) state_n = rst_hit ? PHY_RST : IDLE;
      R_ACK:   state_n = R_TURN1;
      R_TURN1: state_n = R_DATA;
      R_DATA:  state_n = R_TURN2;
      R_TURN2: state_n = IDLE;
      X_TURN1: state_n = X_RXCMD;
      X_RXCMD: state_n = X_TURN2;
      X_TURN2: state_n = IDLE;
      PHY_RST: if (cnt == RESET_LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      6'h00:               rd_data = 8'h24;
      6'h01:               rd_data = 8'h04;
      6'h02:               rd_data = 8'h06;
      6'h04, 6'h05, 6'h06: rd_data = func_ctrl;
      6'h07, 6'h08, 6'h09: rd_data = if_ctrl;
      6'h0A, 6'h0B, 6'h0C: rd_data = otg_ctrl;
      default:             rd_data = 8'h00;
    endcase
  end

  always_comb begin
    NXT      = (state == W_ACK) || (state == W_DATA) || (state == R_ACK);
    DIR      = (state == STARTUP) || (state == R_TURN1) || (state == R_DATA) ||
               (state == X_TURN1) || (state == X_RXCMD) || (state == PHY_RST);
    DATA_OE  = (state == R_DATA) || (state == X_RXCMD);
    DATA_OUT = 8'h00;
    if (state == R_DATA)  DATA_OUT = rd_data;
    if (state == X_RXCMD) DATA_OUT = {4'b0000, cur_rpt};
  end

  always_ff @(posedge USB_CLKIN or negedge NRST) begin
    if (!NRST) begin
      state     <= STARTUP;
      cnt       <= 16'd0;
      addr      <= 6'd0;
      hold      <= 8'h00;
      func_ctrl <= 8'h41;
      if_ctrl   <= 8'h00;
      otg_ctrl  <= 8'h06;
      pending   <= 1'b0;
      last_rpt  <= 4'h0;
    end else begin
      state <= state_n;
      cnt   <= ((state == STARTUP || state == PHY_RST) && state_n == state) ? cnt + 16'd1 : 16'd0;

      if (state == X_RXCMD) begin
        pending  <= 1'b0;
        last_rpt <= cur_rpt;
      end else if (cur_rpt != last_rpt) begin
        pending <= 1'b1;
      end

      if (state == IDLE && DATA_IN[7] == 1'b1) addr <= DATA_IN[5:0];
      if (state == W_DATA) hold <= DATA_IN;

      if (state == W_STP && STP) begin
        case (addr)
          6'h04: func_ctrl <= hold;
          6'h05: func_ctrl <= func_ctrl | hold;
          6'h06: func_ctrl <= func_ctrl & ~hold;
          6'h07: if_ctrl   <= hold;
          6'h08: if_ctrl   <= if_ctrl | hold;
          6'h09: if_ctrl   <= if_ctrl & ~hold;
          6'h0A: otg_ctrl  <= hold;
          6'h0B: otg_ctrl  <= otg_ctrl | hold;
          6'h0C: otg_ctrl  <= otg_ctrl & ~hold;
          default: ;
        endcase
      end

      // Leaving PHY reset: self-clearing reset bit, other registers to defaults.
      if (state == PHY_RST && state_n == IDLE) begin
        func_ctrl[5] <= 1'b0;
        if_ctrl      <= 8'h00;
        otg_ctrl     <= 8'h06;
      end
    end
  end

endmodule

// File: tb/tb_ulpi_phy_responder.sv
// tb/tb_ulpi_phy_responder.sv - scenario-task bench for ulpi_phy_responder with DATA_OUT scoreboard
module tb_ulpi_phy_responder;

  logic       USB_CLKIN = 1'b0;
  logic       NRST;
  logic [7:0] DATA_IN;
  logic [7:0] DATA_OUT;
  logic       DATA_OE;
  logic       DIR;
  logic       NXT;
  logic       STP;
  logic [1:0] LINE_STATE;
  logic [1:0] VBUS_STATE;
  logic [7:0] FUNC_CTRL;
  logic [7:0] OTG_CTRL;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  ulpi_phy_responder #(.STARTUP_CYCLES(4), .RESET_CYCLES(8)) dut (
    .USB_CLKIN (USB_CLKIN),
    .NRST      (NRST),
    .DATA_IN   (DATA_IN),
    .DATA_OUT  (DATA_OUT),
    .DATA_OE   (DATA_OE),
    .DIR       (DIR),
    .NXT       (NXT),
    .STP       (STP),
    .LINE_STATE(LINE_STATE),
    .VBUS_STATE(VBUS_STATE),
    .FUNC_CTRL (FUNC_CTRL),
    .OTG_CTRL  (OTG_CTRL)
  );

  always #8 USB_CLKIN = ~USB_CLKIN;

  task automatic tick;
    @(posedge USB_CLKIN);
    #1;
  endtask

  task automatic do_write(input logic [7:0] cmd, input logic [7:0] data);
    DATA_IN = cmd;
    tick();
    DATA_IN = data;
    tick();
    tick();
    DATA_IN = 8'h00;
    STP = 1'b1;
    tick();
    STP = 1'b0;
  endtask

  task automatic test_reset;
    NRST = 1'b0; DATA_IN = 8'h00; STP = 1'b0;
    repeat (3) tick();
    checks++;
    if ({DIR, NXT, DATA_OE, DATA_OUT, FUNC_CTRL, OTG_CTRL} !== {3'b100, 8'h00, 8'h41, 8'h06}) begin
      errors++;
      $display("FAIL reset_values: dir/nxt/oe=%b%b%b out=%h func=%h otg=%h want 100 00 41 06",
               DIR, NXT, DATA_OE, DATA_OUT, FUNC_CTRL, OTG_CTRL);
    end
    NRST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (DIR !== 1'b1 || DATA_OE !== 1'b0) begin
        errors++;
        $display("FAIL startup_dir cycle %0d: dir=%b oe=%b want dir=1 oe=0", i, DIR, DATA_OE);
      end
      tick();
    end
    checks++;
    if ({DIR, NXT, FUNC_CTRL, OTG_CTRL} !== {2'b00, 8'h41, 8'h06}) begin
      errors++;
      $display("FAIL startup_done: dir=%b nxt=%b func=%h otg=%h want 0 0 41 06", DIR, NXT, FUNC_CTRL, OTG_CTRL);
    end
  endtask

  task automatic test_noop;
    DATA_IN = 8'h40;
    tick();
    DATA_IN = 8'h00;
    STP = 1'b1;
    checks++;
    if (NXT !== 1'b0 || DIR !== 1'b0) begin
      errors++;
      $display("FAIL noop_transmit: nxt=%b dir=%b want 0 0", NXT, DIR);
    end
    tick();
    STP = 1'b0;
    checks++;
    if (NXT !== 1'b0 || DIR !== 1'b0 || FUNC_CTRL !== 8'h41) begin
      errors++;
      $display("FAIL noop_stp_idle: nxt=%b dir=%b func=%h want 0 0 41", NXT, DIR, FUNC_CTRL);
    end
  endtask

  task automatic test_write_otg;
    DATA_IN = 8'h8A;
    tick();
    checks++;
    if (NXT !== 1'b1 || DIR !== 1'b0) begin
      errors++;
      $display("FAIL write_ack_nxt: nxt=%b dir=%b want 1 0", NXT, DIR);
    end
    DATA_IN = 8'h00;
    tick();
    checks++;
    if (NXT !== 1'b1) begin
      errors++;
      $display("FAIL write_data_nxt: nxt=%b want 1", NXT);
    end
    tick();
    checks++;
    if (NXT !== 1'b0 || DIR !== 1'b0) begin
      errors++;
      $display("FAIL write_stp_wait_nxt: nxt=%b dir=%b want 0 0", NXT, DIR);
    end
    tick();
    checks++;
    if (OTG_CTRL !== 8'h06) begin
      errors++;
      $display("FAIL write_no_early_commit: otg=%h want 06", OTG_CTRL);
    end
    STP = 1'b1;
    tick();
    STP = 1'b0;
    checks++;
    if (OTG_CTRL !== 8'h00 || DIR !== 1'b0 || NXT !== 1'b0) begin
      errors++;
      $display("FAIL write_otg_commit: otg=%h dir=%b nxt=%b want 00 0 0", OTG_CTRL, DIR, NXT);
    end
  endtask

  task automatic test_set_clr;
    do_write(8'h8B, 8'h11);
    do_write(8'h8C, 8'h01);
    do_write(8'h90, 8'hFF);
    checks++;
    if (OTG_CTRL !== 8'h10 || FUNC_CTRL !== 8'h41) begin
      errors++;
      $display("FAIL set_clr_otg: otg=%h func=%h want 10 41", OTG_CTRL, FUNC_CTRL);
    end
    do_write(8'h87, 8'h5A);
  endtask

  task automatic test_read(input logic [7:0] cmd, input logic [7:0] expected);
    exp_q.push_back(expected);
    DATA_IN = cmd;
    tick();
    checks++;
    if (NXT !== 1'b1 || DIR !== 1'b0) begin
      errors++;
      $display("FAIL read_ack %h: nxt=%b dir=%b want 1 0", cmd, NXT, DIR);
    end
    DATA_IN = 8'h00;
    tick();
    checks++;
    if (DIR !== 1'b1 || DATA_OE !== 1'b0 || DATA_OUT !== 8'h00 || NXT !== 1'b0) begin
      errors++;
      $display("FAIL read_turn1 %h: dir=%b oe=%b out=%h nxt=%b want 1 0 00 0", cmd, DIR, DATA_OE, DATA_OUT, NXT);
    end
    tick();
    checks++;
    if (DATA_OE !== 1'b1 || DIR !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL read_data_phase %h: oe=%b dir=%b want 1 1", cmd, DATA_OE, DIR);
    end else begin
      exp_b = exp_q.pop_front();
      if (DATA_OUT !== exp_b) begin
        errors++;
        $display("FAIL read_data %h: got %h want %h", cmd, DATA_OUT, exp_b);
      end
    end
    tick();
    checks++;
    if (DIR !== 1'b0 || DATA_OE !== 1'b0 || DATA_OUT !== 8'h00) begin
      errors++;
      $display("FAIL read_turn2 %h: dir=%b oe=%b out=%h want 0 0 00", cmd, DIR, DATA_OE, DATA_OUT);
    end
    tick();
  endtask

  task automatic test_phy_reset;
    do_write(8'h84, 8'h65);
    checks++;
    if (FUNC_CTRL !== 8'h65) begin
      errors++;
      $display("FAIL phy_reset_commit: func=%h want 65", FUNC_CTRL);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (DIR !== 1'b1 || DATA_OE !== 1'b0) begin
        errors++;
        $display("FAIL phy_reset_dir cycle %0d: dir=%b oe=%b want 1 0", i, DIR, DATA_OE);
      end
      tick();
    end
    checks++;
    if (DIR !== 1'b0 || FUNC_CTRL !== 8'h45 || OTG_CTRL !== 8'h06) begin
      errors++;
      $display("FAIL phy_reset_exit: dir=%b func=%h otg=%h want 0 45 06", DIR, FUNC_CTRL, OTG_CTRL);
    end
  endtask

  task automatic test_rxcmd(input logic [1:0] vbus, input logic [1:0] line, input logic [7:0] expected);
    int n;
    exp_q.push_back(expected);
    VBUS_STATE = vbus;
    LINE_STATE = line;
    n = 0;
    while (DIR !== 1'b1 && n < 6) begin
      tick();
      n++;
    end
    checks++;
    if (DIR !== 1'b1 || n != 2 || DATA_OE !== 1'b0) begin
      errors++;
      $display("FAIL rxcmd_turn1 %h: dir=%b oe=%b after %0d cycles want dir=1 oe=0 after 2", expected, DIR, DATA_OE, n);
    end
    tick();
    checks++;
    if (DATA_OE !== 1'b1 || DIR !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL rxcmd_data_phase %h: oe=%b dir=%b want 1 1", expected, DATA_OE, DIR);
    end else begin
      exp_b = exp_q.pop_front();
      if (DATA_OUT !== exp_b) begin
        errors++;
        $display("FAIL rxcmd_data: got %h want %h", DATA_OUT, exp_b);
      end
    end
    tick();
    checks++;
    if (DIR !== 1'b0 || DATA_OE !== 1'b0 || DATA_OUT !== 8'h00) begin
      errors++;
      $display("FAIL rxcmd_turn2 %h: dir=%b oe=%b out=%h want 0 0 00", expected, DIR, DATA_OE, DATA_OUT);
    end
    tick();
    tick();
    checks++;
    if (DIR !== 1'b0) begin
      errors++;
      $display("FAIL rxcmd_no_repeat %h: dir=%b want 0", expected, DIR);
    end
  endtask

  task automatic test_abort;
    DATA_IN = 8'h84;
    tick();
    DATA_IN = 8'h00;
    tick();
    tick();
    test_reset();
  endtask

  task automatic test_write_during_rxcmd;
    DATA_IN = 8'h85;
    tick();
    LINE_STATE = 2'b01;
    exp_q.push_back(8'h01);
    DATA_IN = 8'h02;
    tick();
    tick();
    checks++;
    if (DIR !== 1'b0 || NXT !== 1'b0) begin
      errors++;
      $display("FAIL collide_w_stp: dir=%b nxt=%b want 0 0", DIR, NXT);
    end
    DATA_IN = 8'h00;
    STP = 1'b1;
    tick();
    STP = 1'b0;
    checks++;
    if (FUNC_CTRL !== 8'h43 || DIR !== 1'b0) begin
      errors++;
      $display("FAIL collide_commit: func=%h dir=%b want 43 0", FUNC_CTRL, DIR);
    end
    tick();
    checks++;
    if (DIR !== 1'b1 || DATA_OE !== 1'b0) begin
      errors++;
      $display("FAIL collide_rxcmd_turn1: dir=%b oe=%b want 1 0", DIR, DATA_OE);
    end
    tick();
    checks++;
    if (DATA_OE !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL collide_rxcmd_phase: oe=%b want 1", DATA_OE);
    end else begin
      exp_b = exp_q.pop_front();
      if (DATA_OUT !== exp_b) begin
        errors++;
        $display("FAIL collide_rxcmd_data: got %h want %h", DATA_OUT, exp_b);
      end
    end
    tick();
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    NRST = 1'b0; DATA_IN = 8'h00; STP = 1'b0; LINE_STATE = 2'b00; VBUS_STATE = 2'b00;
    test_reset();
    test_noop();
    test_write_otg();
    test_read(8'hC1, 8'h04);
    test_read(8'hC0, 8'h24);
    test_read(8'hCA, 8'h00);
    test_set_clr();
    test_read(8'hC8, 8'h5A);
    test_phy_reset();
    test_read(8'hC7, 8'h00);
    test_read(8'hC5, 8'h45);
    test_read(8'hCF, 8'h00);
    test_rxcmd(2'b11, 2'b00, 8'h0C);
    test_rxcmd(2'b11, 2'b01, 8'h0D);
    test_rxcmd(2'b00, 2'b00, 8'h00);
    test_abort();
    test_write_during_rxcmd();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d bytes left want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
